// File: rtl/tt_um_dco_core.sv
// tt_um_dco_core: digitally controlled oscillator (programmable half-period divider) in a Tiny Tapeout tile
module tt_um_dco_core #(
  parameter int CNT_W = 8,
  parameter int EDGE_CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [CNT_W-1:0] code_reg, cnt, code_in;
  logic [EDGE_CNT_W-1:0] edge_cnt;
  logic dco_out, dco_div2, rise_pulse;
  logic run, tc, nz, rise;
  logic unused_ok;
  assign code_in = CNT_W'(ui_in);
  assign run = |code_reg;
  assign tc = run && (cnt == code_reg - 1'b1);
  assign nz = |ui_in;
  // a zero code sampled at terminal count parks the output low instead of toggling
  assign rise = tc && !dco_out && nz;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_reg <= '0;
      cnt <= '0;
      dco_out <= 1'b0;
      dco_div2 <= 1'b0;
      rise_pulse <= 1'b0;
      edge_cnt <= '0;
    end else if (ena) begin
      rise_pulse <= rise;
      if (!run) begin
        code_reg <= code_in;
        cnt <= '0;
      end else if (!tc) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        code_reg <= code_in;
        dco_out <= nz & ~dco_out;
      end
      if (rise) begin
        dco_div2 <= ~dco_div2;
        edge_cnt <= edge_cnt + 1'b1;
      end
    end else begin
      rise_pulse <= 1'b0;
    end
  end
  assign uo_out = {4'(edge_cnt), run, rise_pulse, dco_div2, dco_out};
  assign uio_out = 8'h00;
  assign uio_oe = 8'h00;
  assign unused_ok = &{1'b0, uio_in};
endmodule

// File: tb/tb_tt_um_dco_core.sv
// tb_tt_um_dco_core: directed self-checking bench for the DCO tile
module tb_tt_um_dco_core;
  logic clk = 1'b0;
  logic rst_n, ena;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int checks = 0;
  int failures = 0;

  tt_um_dco_core dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // negedges until dco_out is seen going 0->1; 9999 means no rise within the budget
  task automatic wait_rise(output int n);
    logic p;
    n = 9999;
    for (int i = 1; i <= 2000; i++) begin
      p = uo_out[0];
      @(negedge clk);
      if (!p && uo_out[0]) begin
        n = i;
        break;
      end
    end
  endtask

  // negedges until dco_out leaves its current level
  task automatic phase_len(output int n);
    logic v;
    v = uo_out[0];
    n = 9999;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (uo_out[0] !== v) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, x, pulses, d2r, wraps;
    logic pd2;
    logic [3:0] pe;
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h01; uio_in = 8'hA5;
    #25;
    chk("reset_uo", uo_out, 8'h00);
    chk("reset_uio", {uio_out, uio_oe}, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) chk("n1_load", uo_out, 8'h08);
    @(negedge clk) chk("n1_rise1", uo_out, 8'h1F);
    @(negedge clk) chk("n1_fall1", uo_out, 8'h1A);
    @(negedge clk) chk("n1_rise2", uo_out, 8'h2D);

    for (int k = 1; k <= 7; k++) begin
      ui_in = 8'(1 << k);
      wait_rise(x);
      wait_rise(n);
      chk($sformatf("period_n%0d", 1 << k), n, 2 * (1 << k));
    end

    ui_in = 8'd8;
    wait_rise(x);
    wait_rise(x);
    repeat (3) @(negedge clk);
    ui_in = 8'd2;
    phase_len(n);
    chk("midchg_old_rest", n, 5);
    phase_len(n);
    chk("midchg_new_lo", n, 2);
    phase_len(n);
    chk("midchg_new_hi", n, 2);

    ui_in = 8'd4;
    wait_rise(x);
    wait_rise(x);
    phase_len(n);
    chk("n4_hi", n, 4);
    ui_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("zero_pre_tc", {uo_out[3], uo_out[0]}, 2'b10);
    @(negedge clk);
    chk("zero_at_tc", {uo_out[3], uo_out[2], uo_out[0]}, 3'b000);
    repeat (10) @(negedge clk);
    chk("zero_parked", {uo_out[3], uo_out[2], uo_out[0]}, 3'b000);
    ui_in = 8'd4;
    wait_rise(n);
    chk("restart_rise", n, 5);

    @(negedge clk) rst_n = 1'b0;
    #1 chk("async_reset", uo_out, 8'h00);
    ui_in = 8'd1;
    @(negedge clk) rst_n = 1'b1;
    pulses = 0; d2r = 0; wraps = 0; pd2 = 1'b0; pe = 4'd0;
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      if (uo_out[2]) pulses++;
      if (!pd2 && uo_out[1]) d2r++;
      if (pe == 4'd15 && uo_out[7:4] == 4'd0) wraps++;
      pd2 = uo_out[1];
      pe = uo_out[7:4];
    end
    chk("n1_pulses", pulses, 20);
    chk("n1_div2_rises", d2r, 10);
    chk("n1_edge_cnt", uo_out[7:4], 4'd4);
    chk("n1_edge_wrap", wraps, 1);

    @(negedge clk) rst_n = 1'b0;
    ui_in = 8'd16;
    @(negedge clk) rst_n = 1'b1;
    repeat (17) @(negedge clk);
    chk("n16_first_rise", uo_out, 8'h1F);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("ena_hold_%0d", i), {uo_out, uio_out, uio_oe}, {8'h1B, 16'h0000});
    end
    ena = 1'b1;
    phase_len(n);
    chk("ena_resume", n, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
